// File: rtl/xor_unit_scheduler_if.sv
// rtl/xor_unit_scheduler_if.sv - request/response/lane bundle for the quad-XOR scheduler
// resp_parity exists only when XOR_SCHED_PARITY_EN is defined.
interface xor_unit_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_id;
`ifdef XOR_SCHED_PARITY_EN
  logic              resp_parity;
`endif
  logic [3:0]        lane_a;
  logic [3:0]        lane_b;
  logic [3:0]        lane_y;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready, lane_y,
`ifdef XOR_SCHED_PARITY_EN
    input  resp_parity,
`endif
    input  req0_ready, req1_ready, resp_valid, resp_data, resp_id, lane_a, lane_b
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready, lane_y,
`ifdef XOR_SCHED_PARITY_EN
    output resp_parity,
`endif
    output req0_ready, req1_ready, resp_valid, resp_data, resp_id, lane_a, lane_b
  );
endinterface

// File: rtl/xor_unit_scheduler.sv
// rtl/xor_unit_scheduler.sv - two-requester arbiter and nibble sequencer for the shared quad-XOR
// Optional result parity output enabled by defining XOR_SCHED_PARITY_EN.
module xor_unit_scheduler #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  xor_unit_scheduler_if.slave   bus
);
  localparam int N  = DATA_W / 4;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [BW-1:0]     r_beat;
  logic              r_last_grant;
  logic              r_id;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;

  logic              w_grant_id;
  logic              w_ready0;
  logic              w_ready1;
  logic              w_accept;
  logic              w_resp_valid;
  logic              w_last_beat;
  logic [BW+1:0]     w_sh;
  logic [DATA_W-1:0] w_shift_a;
  logic [DATA_W-1:0] w_shift_b;
  logic [DATA_W-1:0] w_res_next;
  logic [3:0]        w_lane_a;
  logic [3:0]        w_lane_b;

  // Requester 1 wins only when alone or when requester 0 had the previous grant.
  assign w_grant_id  = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
  assign w_last_beat = (r_beat == BW'(N - 1));
  assign w_sh        = {r_beat, 2'b00};
  assign w_shift_a   = r_a >> w_sh;
  assign w_shift_b   = r_b >> w_sh;
  assign w_res_next  = (r_res & ~(DATA_W'(4'hF) << w_sh)) | (DATA_W'(bus.lane_y) << w_sh);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_ready0     = 1'b0;
    w_ready1     = 1'b0;
    w_accept     = 1'b0;
    w_resp_valid = 1'b0;
    w_lane_a     = 4'h0;
    w_lane_b     = 4'h0;
    case (r_state)
      IDLE: begin
        if (!rst) begin
          w_ready0 = bus.req0_valid && !w_grant_id;
          w_ready1 = bus.req1_valid &&  w_grant_id;
        end
        w_accept = w_ready0 || w_ready1;
        if (w_accept) w_next = RUN;
      end
      RUN: begin
        w_lane_a = w_shift_a[3:0];
        w_lane_b = w_shift_b[3:0];
        if (w_last_beat) w_next = DONE;
      end
      DONE: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat       <= '0;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
    end else begin
      if (w_accept) begin
        r_a          <= w_grant_id ? bus.req1_a : bus.req0_a;
        r_b          <= w_grant_id ? bus.req1_b : bus.req0_b;
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
        r_beat       <= '0;
      end
      if (r_state == RUN) begin
        r_res <= w_res_next;
        if (!w_last_beat) r_beat <= r_beat + BW'(1);
      end
    end
  end

`ifdef XOR_SCHED_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst)                             r_parity <= 1'b0;
    else if (r_state == RUN && w_last_beat) r_parity <= ^w_res_next;
  end

  assign bus.resp_parity = r_parity;
`endif

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_data  = r_res;
  assign bus.resp_id    = r_id;
  assign bus.lane_a     = w_lane_a;
  assign bus.lane_b     = w_lane_b;
endmodule

// File: tb/tb_xor_unit_scheduler.sv
// tb/tb_xor_unit_scheduler.sv - directed self-checking bench for xor_unit_scheduler
module tb_xor_unit_scheduler;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  xor_unit_scheduler_if #(.DATA_W(DW)) bus ();
  assign bus.lane_y = bus.lane_a ^ bus.lane_b;

  xor_unit_scheduler #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b expected 0", bus.req0_ready); end
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b expected 0", bus.req1_ready); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 8'h00) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 00", bus.resp_data); end
    n_checks++; if (bus.resp_id !== 1'b0) begin n_fail++; $display("FAIL reset_resp_id: got %b expected 0", bus.resp_id); end
    n_checks++; if (bus.lane_a !== 4'h0 || bus.lane_b !== 4'h0) begin n_fail++; $display("FAIL reset_lanes: got %h/%h expected 0/0", bus.lane_a, bus.lane_b); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 1", bus.req0_ready); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_a = 8'h5A; bus.req0_b = 8'hFF;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready: got %b%b expected 10", bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    n_checks++; if (bus.lane_a !== 4'hA || bus.lane_b !== 4'hF) begin n_fail++; $display("FAIL single_beat0: got %h/%h expected a/f", bus.lane_a, bus.lane_b); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", bus.resp_valid); end
    @(negedge clk);
    n_checks++; if (bus.lane_a !== 4'h5 || bus.lane_b !== 4'hF) begin n_fail++; $display("FAIL single_beat1: got %h/%h expected 5/f", bus.lane_a, bus.lane_b); end
    @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %b expected 1", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 8'hA5 || bus.resp_id !== 1'b0) begin n_fail++; $display("FAIL single_resp: got %h id %b expected a5 id 0", bus.resp_data, bus.resp_id); end
    n_checks++; if (bus.lane_a !== 4'h0 || bus.lane_b !== 4'h0) begin n_fail++; $display("FAIL single_done_lanes: got %h/%h expected 0/0", bus.lane_a, bus.lane_b); end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b expected 0", bus.resp_valid); end
  endtask

  task automatic test_contention();
    bit ok;
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 8'h0F; bus.req0_b = 8'hF0;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h33; bus.req1_b = 8'h33;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL contention_grant0: got %b%b expected 10", bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL contention_wait_run: got %b expected 0", bus.req1_ready); end
    wait_resp(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL contention_timeout0: got no resp expected resp"); end
    n_checks++; if (bus.resp_data !== 8'hFF || bus.resp_id !== 1'b0) begin n_fail++; $display("FAIL contention_resp0: got %h id %b expected ff id 0", bus.resp_data, bus.resp_id); end
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL contention_wait_done: got %b expected 0", bus.req1_ready); end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL contention_grant1: got %b expected 1", bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    wait_resp(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL contention_timeout1: got no resp expected resp"); end
    n_checks++; if (bus.resp_data !== 8'h00 || bus.resp_id !== 1'b1) begin n_fail++; $display("FAIL contention_resp1: got %h id %b expected 00 id 1", bus.resp_data, bus.resp_id); end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 8'h12; bus.req0_b = 8'h34;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 8'hC0; bus.req1_b = 8'h0C;
    wait_resp(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no resp expected resp"); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 8'h26 || bus.resp_id !== 1'b0 || bus.req1_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    bus.resp_ready = 1'b1;
    #1;
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_bypass: got %b expected 0", bus.req1_ready); end
    @(negedge clk);
    bus.resp_ready = 1'b0;
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_after: got valid %b ready1 %b expected 0 1", bus.resp_valid, bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    wait_resp(ok);
    n_checks++; if (!ok || bus.resp_data !== 8'hCC || bus.resp_id !== 1'b1) begin n_fail++; $display("FAIL bp_next_op: got %h id %b expected cc id 1", bus.resp_data, bus.resp_id); end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int stray;
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 8'hC3; bus.req0_b = 8'h00;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.lane_a !== 4'hC) begin n_fail++; $display("FAIL midrun_beat1: got %h expected c", bus.lane_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.lane_a !== 4'h0 || bus.lane_b !== 4'h0) begin n_fail++; $display("FAIL midrun_abort: got valid %b lanes %h/%h expected 0 0/0", bus.resp_valid, bus.lane_a, bus.lane_b); end
    bus.resp_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.resp_valid !== 1'b0) stray++;
      @(negedge clk);
    end
    bus.resp_ready = 1'b0;
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL midrun_stray: got %0d resp cycles expected 0", stray); end
    bus.req1_valid = 1'b1;
    #1;
    n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_idle: got %b expected 1", bus.req1_ready); end
    bus.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [DW-1:0] exp_data;
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 8'h11; bus.req0_b = 8'h22;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h44; bus.req1_b = 8'h88;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_resp(ok);
      exp_data = (k % 2 == 0) ? 8'h33 : 8'hCC;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL fair_timeout_%0d: got no resp expected resp", k); end
      n_checks++; if (bus.resp_id !== 1'(k % 2) || bus.resp_data !== exp_data) begin n_fail++; $display("FAIL fair_op_%0d: got %h id %b expected %h id %0d", k, bus.resp_data, bus.resp_id, exp_data, k % 2); end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

`ifdef XOR_SCHED_PARITY_EN
  task automatic test_parity();
    bit ok;
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h00;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_resp(ok);
    n_checks++; if (!ok || bus.resp_parity !== 1'b1) begin n_fail++; $display("FAIL parity_odd: got %b expected 1", bus.resp_parity); end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h03; bus.req0_b = 8'h00;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_resp(ok);
    n_checks++; if (!ok || bus.resp_parity !== 1'b0) begin n_fail++; $display("FAIL parity_even: got %b expected 0", bus.resp_parity); end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef XOR_SCHED_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
